// File: rtl/word_packer_32to64.sv
// ----------------------------------------------------------------------------
// word_packer_32to64
//
// Write-side companion of the 64-bit-in / 32-bit-out acquisition data FIFO.
// Packs pairs of 32-bit words from a valid/ready stream into 64-bit words and
// writes them into the FIFO through din/wr_en, honouring the FIFO full flag.
// A packet ending on an odd word is flushed with PAD_WORD in the missing half.
// Word order is arranged so the FIFO's 32-bit read side returns the words in
// their original order.
//
// Parameters:
//   HI_FIRST   1: first word of a pair goes to [63:32]; 0: to [31:0]
//   PAD_WORD   filler half used when a packet ends on an odd word
//
// Ports:
//   clk         write-side clock
//   rst_n       asynchronous active-low reset
//   in_data     input word
//   in_valid    in_data valid
//   in_last     final word of packet; flushes a partial pair
//   in_ready    block accepts the word this cycle
//   fifo_din    packed word to FIFO din (registered out slot)
//   fifo_wr_en  FIFO write strobe
//   fifo_full   FIFO full flag
//   busy        half-word held or packed word pending
//   word_cnt    count of 64-bit words written
//
// Build option:
//   PACK_CNT_EN  when defined, word_cnt counts FIFO writes (wrapping);
//                otherwise word_cnt is tied to zero and no counter is built.
// ----------------------------------------------------------------------------
module word_packer_32to64 #(
    parameter bit          HI_FIRST = 1'b1,
    parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic [31:0] word_cnt
);

    typedef enum logic {
        StEmpty,
        StHalf
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [63:0] out_q, out_d;
    logic        out_vld_q, out_vld_d;
    // Keeps in_ready low during reset and releases it on the first clock after.
    logic        rdy_en_q;

    logic        accept;
    logic        load;
    logic [63:0] load_word;

    // Places the earlier word of a pair according to HI_FIRST.
    function automatic logic [63:0] pack(input logic [31:0] first, input logic [31:0] second);
        if (HI_FIRST) begin
            return {first, second};
        end else begin
            return {second, first};
        end
    endfunction

    // ------------------------------------------------------------------------
    // Handshake and FIFO write strobe
    // ------------------------------------------------------------------------
    // The out slot can take a new word when it is empty or drains this cycle.
    assign in_ready   = rdy_en_q & (~out_vld_q | ~fifo_full);
    assign accept     = in_valid & in_ready;
    assign fifo_wr_en = out_vld_q & ~fifo_full;
    assign fifo_din   = out_q;
    assign busy       = (state_q == StHalf) | out_vld_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        load      = 1'b0;
        load_word = '0;

        if (accept) begin
            unique case (state_q)
                StEmpty: begin
                    if (in_last) begin
                        // Odd-length packet: flush immediately with the filler.
                        load      = 1'b1;
                        load_word = pack(in_data, PAD_WORD);
                    end else begin
                        hold_d  = in_data;
                        state_d = StHalf;
                    end
                end
                StHalf: begin
                    // Pair is complete, so in_last needs no special handling.
                    load      = 1'b1;
                    load_word = pack(hold_q, in_data);
                    state_d   = StEmpty;
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // A load in the same cycle as a drain keeps the slot occupied.
    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q & ~fifo_wr_en;
        if (load) begin
            out_d     = load_word;
            out_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            hold_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            rdy_en_q  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Optional write counter
    // ------------------------------------------------------------------------
`ifdef PACK_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Wraps naturally from all-ones to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (fifo_wr_en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_word_packer_32to64.sv
// Self-checking bench for word_packer_32to64: two instances (HI_FIRST=1 and 0)
// share one stimulus stream; a scoreboard queue per instance holds the packed
// words expected at the FIFO write port.
module tb_word_packer_32to64;

    localparam logic [31:0] PAD_HI = 32'hDEAD_BEEF;
    localparam logic [31:0] PAD_LO = 32'h1234_5678;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        fifo_full;

    logic        in_ready_hi, in_ready_lo;
    logic [63:0] din_hi, din_lo;
    logic        wr_hi, wr_lo;
    logic        busy_hi, busy_lo;
    logic [31:0] cnt_hi, cnt_lo;

    word_packer_32to64 #(
        .HI_FIRST (1'b1),
        .PAD_WORD (PAD_HI)
    ) dut_hi (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready_hi),
        .fifo_din   (din_hi),
        .fifo_wr_en (wr_hi),
        .fifo_full  (fifo_full),
        .busy       (busy_hi),
        .word_cnt   (cnt_hi)
    );

    word_packer_32to64 #(
        .HI_FIRST (1'b0),
        .PAD_WORD (PAD_LO)
    ) dut_lo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready_lo),
        .fifo_din   (din_lo),
        .fifo_wr_en (wr_lo),
        .fifo_full  (fifo_full),
        .busy       (busy_lo),
        .word_cnt   (cnt_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_hi[$];
    logic [63:0] q_lo[$];
    logic        ph_valid;
    logic [31:0] ph_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference pairing model, fed with every accepted word.
    task automatic model_accept(input logic [31:0] d, input logic last);
        if (!ph_valid) begin
            if (last) begin
                q_hi.push_back({d, PAD_HI});
                q_lo.push_back({PAD_LO, d});
            end else begin
                ph_valid = 1'b1;
                ph_word  = d;
            end
        end else begin
            q_hi.push_back({ph_word, d});
            q_lo.push_back({d, ph_word});
            ph_valid = 1'b0;
        end
    endtask

    task automatic model_clear();
        q_hi.delete();
        q_lo.delete();
        ph_valid = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic last);
        logic rdy;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n        = 0;
        do begin
            @(negedge clk);
            rdy = in_ready_hi;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        check("send_accepted", rdy, 1);
        if (rdy) model_accept(d, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every FIFO write is matched against the expected queue.
    always @(negedge clk) begin
        if (wr_hi) begin
            check("hi_wr_while_full", fifo_full, 0);
            check("hi_sb_has_entry", q_hi.size() != 0, 1);
            if (q_hi.size() != 0) check("hi_sb_din", din_hi, q_hi.pop_front());
        end
        if (wr_lo) begin
            check("lo_wr_while_full", fifo_full, 0);
            check("lo_sb_has_entry", q_lo.size() != 0, 1);
            if (q_lo.size() != 0) check("lo_sb_din", din_lo, q_lo.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    logic [63:0] exp_cnt;

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        ph_valid  = 1'b0;
        ph_word   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready_hi, 0);
        check("rst_din", din_hi, 0);
        check("rst_wr_en", wr_hi, 0);
        check("rst_busy", busy_hi, 0);
        check("rst_word_cnt", cnt_hi, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_hi, 1);
        check("ready_match", in_ready_lo, in_ready_hi);
        @(posedge clk);
        #1;

        // Basic pair, both orderings, one-cycle latency
        send(32'hAAAA_0001, 1'b0);
        check("half_busy", busy_hi, 1);
        check("half_no_wr", wr_hi, 0);
        send(32'hBBBB_0002, 1'b0);
        @(negedge clk);
        check("pair_wr_latency", wr_hi, 1);
        check("pair_din_hi", din_hi, 64'hAAAA_0001_BBBB_0002);
        check("pair_din_lo", din_lo, 64'hBBBB_0002_AAAA_0001);
        @(posedge clk);
        #1;
        check("pair_busy_clear", busy_hi, 0);
        check("pair_wr_clear", wr_hi, 0);

        // Odd packet flushed with the pad word
        send(32'h1111_0001, 1'b0);
        send(32'h2222_0002, 1'b0);
        send(32'h0000_0003, 1'b1);
        @(negedge clk);
        check("pad_wr", wr_hi, 1);
        check("pad_din_hi", din_hi, 64'h0000_0003_DEAD_BEEF);
        check("pad_din_lo", din_lo, 64'h1234_5678_0000_0003);
        idle(3);

        // Back-pressure: FIFO full for 10 cycles while streaming 6 words
        fifo_full = 1'b1;
        fork
            begin
                send(32'hC000_0001, 1'b0);
                send(32'hC000_0002, 1'b0);
                send(32'hC000_0003, 1'b0);
                send(32'hC000_0004, 1'b0);
                send(32'hC000_0005, 1'b0);
                send(32'hC000_0006, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("full_din_early", din_hi, 64'hC000_0001_C000_0002);
                check("full_ready_early", in_ready_hi, 0);
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("full_ready_late", in_ready_hi, 0);
                check("full_no_wr", wr_hi, 0);
                check("full_din_stable", din_hi, 64'hC000_0001_C000_0002);
                check("full_busy", busy_hi, 1);
                @(posedge clk);
                #1;
                fifo_full = 1'b0;
            end
        join
        idle(4);
        check("full_all_written_hi", q_hi.size(), 0);
        check("full_all_written_lo", q_lo.size(), 0);
        check("full_busy_clear", busy_hi, 0);

        // Asynchronous reset while a half-word is held
        send(32'h5555_0005, 1'b0);
        check("rstA_busy_before", busy_hi, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstA_busy", busy_hi, 0);
        check("rstA_ready", in_ready_hi, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h6666_0006, 1'b0);
        send(32'h7777_0007, 1'b0);
        @(negedge clk);
        check("rstA_clean_pair", din_hi, 64'h6666_0006_7777_0007);
        idle(2);

        // Asynchronous reset while a packed word is pending behind full
        fifo_full = 1'b1;
        send(32'h8888_0008, 1'b0);
        send(32'h9999_0009, 1'b0);
        check("rstB_pending_busy", busy_hi, 1);
        check("rstB_pending_no_wr", wr_hi, 0);
        #2;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        #1;
        check("rstB_no_wr", wr_hi, 0);
        check("rstB_busy", busy_hi, 0);
        check("rstB_din", din_hi, 0);
        model_clear();
        @(negedge clk);
        check("rstB_still_no_wr", wr_hi, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'hABCD_0010, 1'b0);
        send(32'hABCD_0011, 1'b0);
        @(negedge clk);
        check("rstB_clean_pair", din_hi, 64'hABCD_0010_ABCD_0011);
        check("rstB_clean_pair_lo", din_lo, 64'hABCD_0011_ABCD_0010);
        idle(2);

        // Write counter
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(32'hF000_0000 + 32'(2 * i), 1'b0);
            send(32'hF000_0001 + 32'(2 * i), 1'b0);
        end
        idle(3);
`ifdef PACK_CNT_EN
        exp_cnt = 64'd8;
`else
        exp_cnt = 64'd0;
`endif
        check("word_cnt_8_pairs", cnt_hi, exp_cnt);
        check("word_cnt_lo", cnt_lo, exp_cnt);
`ifdef PACK_CNT_EN
        force dut_hi.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut_hi.cnt_q;
        @(posedge clk);
        #1;
        send(32'h0BAD_0001, 1'b0);
        send(32'h0BAD_0002, 1'b0);
        idle(3);
        check("word_cnt_wrap", cnt_hi, 0);
`endif

        idle(3);
        check("end_sb_empty_hi", q_hi.size(), 0);
        check("end_sb_empty_lo", q_lo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
